// File: rtl/log_wupd_scheduler_pkg.sv
// log_wupd_scheduler_pkg: shared log-word constants and sequencer state encoding
package log_wupd_scheduler_pkg;

    localparam int LOG_WIDTH_DEF = 17;
    localparam int LOG_QP        = 12;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_SKIP  = 3'd4
    } state_t;

endpackage

// File: rtl/log_wupd_scheduler_delay_n_arst.sv
// delay_n_arst: N-stage register delay line with asynchronous active-low clear
module delay_n_arst #(
    parameter int W = 1,
    parameter int N = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_pipe [N];

    // shift the input through N stages, clearing every stage on reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < N; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[N-1];

endmodule

// File: rtl/log_wupd_scheduler.sv
// log_wupd_scheduler: sequences one shared log-domain weight-update unit over all taps
module log_wupd_scheduler
    import log_wupd_scheduler_pkg::*;
#(
    parameter int NTAPS     = 8,
    parameter int AW        = 3,
    parameter int LOG_WIDTH = LOG_WIDTH_DEF,
    parameter int RD_LAT    = 1,
    parameter int UPD_LAT   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_adapt_en,
    input  logic [LOG_WIDTH-1:0] i_log_mu_error,
    input  logic                 i_log_error_sign,
    input  logic                 i_log_error_valid,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_skipped,
    output logic                 o_start_drop,
    output logic                 o_x_rd_en,
    output logic [AW-1:0]        o_tap_addr,
    output logic                 o_upd_en,
    output logic [LOG_WIDTH-1:0] o_upd_err,
    output logic                 o_upd_err_sign,
    output logic                 o_upd_err_valid,
    output logic                 o_wb_en,
    output logic [AW-1:0]        o_wb_addr
);

    localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

    state_t               r_state;
    logic [AW-1:0]        r_tap;
    logic                 r_x_rd_en;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_skipped;
    logic [LOG_WIDTH-1:0] r_err;
    logic                 r_err_sign;
    logic                 r_err_valid;
    logic [AW-1:0]        w_upd_addr;
    logic                 w_last_wb;

    // the update enable trails the read strobe by the buffer read latency
    delay_n_arst #(.W(AW + 1), .N(RD_LAT)) u_rd_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     ({r_x_rd_en, r_tap}),
        .o_q     ({o_upd_en, w_upd_addr})
    );

    // the write-back strobe trails the update enable by the update-unit latency
    delay_n_arst #(.W(AW + 1), .N(UPD_LAT)) u_upd_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     ({o_upd_en, w_upd_addr}),
        .o_q     ({o_wb_en, o_wb_addr})
    );

    assign w_last_wb = o_wb_en && (o_wb_addr == LAST);

    // pass sequencer: issue taps, drain the pipeline, then report completion
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_tap       <= '0;
            r_x_rd_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_skipped   <= 1'b0;
            r_err       <= '0;
            r_err_sign  <= 1'b0;
            r_err_valid <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_skipped <= 1'b0;
            case (r_state)
                S_ISSUE: begin
                    if (r_tap == LAST) begin
                        r_x_rd_en <= 1'b0;
                        r_state   <= S_DRAIN;
                    end else begin
                        r_tap <= r_tap + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_last_wb) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    if (i_start) begin
                        r_err       <= i_log_mu_error;
                        r_err_sign  <= i_log_error_sign;
                        r_err_valid <= i_log_error_valid;
                        if (i_adapt_en && i_log_error_valid) begin
                            r_tap     <= '0;
                            r_x_rd_en <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= S_ISSUE;
                        end else begin
                            r_done    <= 1'b1;
                            r_skipped <= 1'b1;
                            r_state   <= S_SKIP;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_skipped       = r_skipped;
    assign o_start_drop    = i_start && r_busy;
    assign o_x_rd_en       = r_x_rd_en;
    assign o_tap_addr      = r_tap;
    assign o_upd_err       = r_err;
    assign o_upd_err_sign  = r_err_sign;
    assign o_upd_err_valid = r_err_valid;

endmodule

// File: tb/tb_log_wupd_scheduler.sv
// tb_log_wupd_scheduler: randomized and directed check against a cycle-schedule model
module tb_log_wupd_scheduler;

    localparam int NT   = 4;
    localparam int AW   = 3;
    localparam int LW   = 17;
    localparam int RD   = 1;
    localparam int UPD  = 2;
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          adapt_en = 1'b0;
    logic [LW-1:0] log_mu_error = '0;
    logic          log_error_sign = 1'b0;
    logic          log_error_valid = 1'b0;
    logic          busy, done, skipped, start_drop, x_rd_en, upd_en, wb_en;
    logic          upd_err_sign, upd_err_valid;
    logic [AW-1:0] tap_addr, wb_addr;
    logic [LW-1:0] upd_err;

    int checks = 0;
    int errors = 0;
    int cyc = -1;
    int free_at = 0;

    bit            e_x   [MAXC];
    bit            e_upd [MAXC];
    bit            e_wb  [MAXC];
    bit            e_busy[MAXC];
    bit            e_done[MAXC];
    bit            e_skip[MAXC];
    int            e_xa  [MAXC];
    int            e_wa  [MAXC];
    logic [LW+1:0] e_err [MAXC];
    bit            e_drop;

    log_wupd_scheduler #(
        .NTAPS(NT), .AW(AW), .LOG_WIDTH(LW), .RD_LAT(RD), .UPD_LAT(UPD)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_start           (start),
        .i_adapt_en        (adapt_en),
        .i_log_mu_error    (log_mu_error),
        .i_log_error_sign  (log_error_sign),
        .i_log_error_valid (log_error_valid),
        .o_busy            (busy),
        .o_done            (done),
        .o_skipped         (skipped),
        .o_start_drop      (start_drop),
        .o_x_rd_en         (x_rd_en),
        .o_tap_addr        (tap_addr),
        .o_upd_en          (upd_en),
        .o_upd_err         (upd_err),
        .o_upd_err_sign    (upd_err_sign),
        .o_upd_err_valid   (upd_err_valid),
        .o_wb_en           (wb_en),
        .o_wb_addr         (wb_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic wipe(input int from);
        for (int j = from; j < MAXC; j++) begin
            e_x[j] = 0; e_upd[j] = 0; e_wb[j] = 0; e_busy[j] = 0;
            e_done[j] = 0; e_skip[j] = 0; e_err[j] = '0;
        end
    endtask

    task automatic step(input bit rst, input bit st, input bit ad, input bit va,
                        input logic [LW-1:0] e, input bit sg);
        @(posedge clk);
        #1;
        cyc++;
        rst_n = !rst;
        start = st && !rst;
        adapt_en = ad;
        log_error_valid = va;
        log_mu_error = e;
        log_error_sign = sg;
        e_drop = 0;
        if (rst) begin
            wipe(cyc);
            free_at = cyc + 1;
        end else if (st && cyc >= free_at) begin
            for (int j = cyc + 1; j < MAXC; j++) e_err[j] = {va, sg, e};
            if (ad && va) begin
                for (int k = 0; k < NT; k++) begin
                    e_x[cyc+1+k] = 1;
                    e_xa[cyc+1+k] = k;
                    e_upd[cyc+1+k+RD] = 1;
                    e_wb[cyc+1+k+RD+UPD] = 1;
                    e_wa[cyc+1+k+RD+UPD] = k;
                end
                for (int j = cyc + 1; j <= cyc + NT + RD + UPD; j++) e_busy[j] = 1;
                free_at = cyc + NT + RD + UPD + 1;
                e_done[free_at] = 1;
            end else begin
                free_at = cyc + 1;
                e_done[free_at] = 1;
                e_skip[free_at] = 1;
            end
        end else if (st) begin
            e_drop = 1;
        end
        @(negedge clk);
        check("busy", 32'(busy), 32'(e_busy[cyc]));
        check("done", 32'(done), 32'(e_done[cyc]));
        check("skipped", 32'(skipped), 32'(e_skip[cyc]));
        check("start_drop", 32'(start_drop), 32'(e_drop));
        check("x_rd_en", 32'(x_rd_en), 32'(e_x[cyc]));
        if (e_x[cyc]) check("tap_addr", 32'(tap_addr), 32'(e_xa[cyc]));
        check("upd_en", 32'(upd_en), 32'(e_upd[cyc]));
        check("wb_en", 32'(wb_en), 32'(e_wb[cyc]));
        if (e_wb[cyc]) check("wb_addr", 32'(wb_addr), 32'(e_wa[cyc]));
        check("upd_err", 32'({upd_err_valid, upd_err_sign, upd_err}), 32'(e_err[cyc]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0);
    endtask

    initial begin
        wipe(0);
        step(1, 0, 0, 0, '0, 0);
        step(1, 0, 0, 0, '0, 0);
        step(0, 1, 1, 1, 17'h01800, 0);
        idle(2);
        step(0, 1, 1, 1, 17'h0F0F0, 1);
        idle(4);
        step(0, 1, 1, 1, 17'h1F000, 1);
        idle(10);
        step(0, 1, 1, 0, 17'h00123, 0);
        idle(3);
        step(0, 1, 0, 1, 17'h0ABCD, 1);
        idle(3);
        step(0, 1, 1, 1, 17'h05555, 0);
        idle(4);
        step(1, 0, 0, 0, '0, 0);
        idle(4);
        step(0, 1, 1, 1, 17'h1AAAA, 1);
        idle(10);
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            step(r < 2, (r >= 2) && ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0,
                 LW'($urandom), 1'($urandom));
        end
        idle(12);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
